// File: rtl/mc_muldiv_unit.sv
// mc_muldiv_unit
// Multi-cycle integer multiply/divide unit for the EX stage. It handles one
// operation per accepted start and iterates one bit per clock: shift-add
// multiply or restoring divide. Signed operations run on magnitudes, and
// the signs are applied in a final fix-up cycle.
//
// Ports:
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset
//   start     operation request, sampled only while idle
//   flush     synchronous abort; returns to idle without updating outputs
//   Op        000 MULT, 001 MULTU, 010 DIV, 011 DIVU, others illegal
//   A, B      multiplicand/dividend, multiplier/divisor
//   busy      operation in progress (RUN or FIX)
//   done      one-cycle pulse; result outputs valid
//   Result    product low half / quotient
//   ResultHi  product high half / remainder
//   Zero      Result and ResultHi both zero
//   DivZero   last operation was a divide by zero
//   Illegal   last operation used an unused Op code
module mc_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             flush,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] ResultHi,
    output logic             Zero,
    output logic             DivZero,
    output logic             Illegal
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t r_state, w_next;

    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;    // mult: {partial high, multiplier}; div: {rem, quot}
    logic [WIDTH-1:0]   r_opnd;   // multiplicand magnitude or divisor magnitude
    logic               r_is_div;
    logic               r_neg_q;  // product/quotient sign
    logic               r_neg_r;  // remainder sign follows the dividend
    logic               r_dz;
    logic               r_ill;

    logic               w_capture;
    logic               w_commit;
    logic               w_last;

    // Operand decode at capture
    logic               w_signed;
    logic               w_div;
    logic               w_ill;
    logic               w_dz;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;

    // Iteration datapath
    logic [WIDTH:0]     w_msum;
    logic [WIDTH:0]     w_rem_sh;
    logic               w_ge;
    logic [WIDTH-1:0]   w_dsub;
    logic [2*WIDTH-1:0] w_acc_nxt;

    // Fix-up results
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_res;
    logic [WIDTH-1:0]   w_res_hi;

    assign w_signed = (Op == 3'b000) || (Op == 3'b010);
    assign w_div    = (Op == 3'b010) || (Op == 3'b011);
    assign w_ill    = Op[2];
    assign w_dz     = w_div && (B == '0);
    // Negating the most negative value yields the same bit pattern, which is
    // the correct unsigned magnitude 2^(WIDTH-1).
    assign w_mag_a  = (w_signed && A[WIDTH-1]) ? -A : A;
    assign w_mag_b  = (w_signed && B[WIDTH-1]) ? -B : B;

    assign w_capture = (r_state == S_IDLE) && start && !flush;
    assign w_commit  = (r_state == S_FIX) && !flush;
    assign w_last    = (r_cnt == CW'(WIDTH - 1));
    assign busy      = (r_state != S_IDLE);

    // Next-state logic
    always_comb begin
        w_next = r_state;
        if (flush) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (start) w_next = (w_ill || w_dz) ? S_FIX : S_RUN;
                S_RUN:  if (w_last) w_next = S_FIX;
                S_FIX:  w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // One iteration step for either operation
    always_comb begin
        w_msum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_opnd : '0)};
        // The shifted remainder needs one extra bit before the trial subtract.
        w_rem_sh  = r_acc[2*WIDTH-1:WIDTH-1];
        w_ge      = (w_rem_sh >= {1'b0, r_opnd});
        w_dsub    = w_rem_sh[WIDTH-1:0] - r_opnd;
        w_acc_nxt = {w_msum, r_acc[WIDTH-1:1]};
        if (r_is_div) begin
            w_acc_nxt = w_ge ? {w_dsub, r_acc[WIDTH-2:0], 1'b1}
                             : {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
        end
    end

    // Datapath registers carry no reset; control decides when they matter.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_is_div <= w_div;
            r_neg_q  <= w_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
            r_neg_r  <= w_signed && A[WIDTH-1];
            r_dz     <= w_dz;
            r_ill    <= w_ill;
            if (w_dz) begin
                r_acc  <= {{WIDTH{1'b0}}, A};
                r_opnd <= '0;
            end else if (w_div) begin
                r_acc  <= {{WIDTH{1'b0}}, w_mag_a};
                r_opnd <= w_mag_b;
            end else begin
                r_acc  <= {{WIDTH{1'b0}}, w_mag_b};
                r_opnd <= w_mag_a;
            end
        end else if ((r_state == S_RUN) && !flush) begin
            r_acc <= w_acc_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (w_capture) begin
            r_cnt <= '0;
        end else if ((r_state == S_RUN) && !flush) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Sign fix-up and result selection
    always_comb begin
        w_prod   = r_neg_q ? -r_acc : r_acc;
        w_quot   = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
        w_rem    = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
        w_res    = w_prod[WIDTH-1:0];
        w_res_hi = w_prod[2*WIDTH-1:WIDTH];
        if (r_ill) begin
            w_res    = '0;
            w_res_hi = '0;
        end else if (r_dz) begin
            w_res    = '1;
            w_res_hi = r_acc[WIDTH-1:0];
        end else if (r_is_div) begin
            w_res    = w_quot;
            w_res_hi = w_rem;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done     <= 1'b0;
            Result   <= '0;
            ResultHi <= '0;
            Zero     <= 1'b1;
            DivZero  <= 1'b0;
            Illegal  <= 1'b0;
        end else begin
            done <= w_commit;
            if (w_capture) begin
                DivZero <= 1'b0;
                Illegal <= 1'b0;
            end
            if (w_commit) begin
                Result   <= w_res;
                ResultHi <= w_res_hi;
                Zero     <= (w_res == '0) && (w_res_hi == '0);
                DivZero  <= r_dz;
                Illegal  <= r_ill;
            end
        end
    end

endmodule

// File: tb/tb_mc_muldiv_unit.sv
module tb_mc_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  Op = 3'b000;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        busy;
    logic        done;
    logic [31:0] Result;
    logic [31:0] ResultHi;
    logic        Zero;
    logic        DivZero;
    logic        Illegal;

    mc_muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .flush(flush),
        .Op(Op), .A(A), .B(B), .busy(busy), .done(done),
        .Result(Result), .ResultHi(ResultHi), .Zero(Zero),
        .DivZero(DivZero), .Illegal(Illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] hi;
        logic        z;
        logic        dz;
        logic        ill;
    } exp_t;

    exp_t q[$];
    exp_t last;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares every done pulse against the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n && done === 1'b1) begin
                if (q.size() == 0) begin
                    chk("unexpected done", 64'(done), 64'(0));
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("Result",   64'(Result),   64'(e.res));
                    chk("ResultHi", 64'(ResultHi), 64'(e.hi));
                    chk("Zero",     64'(Zero),     64'(e.z));
                    chk("DivZero",  64'(DivZero),  64'(e.dz));
                    chk("Illegal",  64'(Illegal),  64'(e.ill));
                end
            end
        end
    end

    function automatic exp_t mk(input logic [31:0] r, input logic [31:0] h,
                                input logic dz, input logic il);
        exp_t e;
        e.res = r; e.hi = h; e.z = (r == 0) && (h == 0); e.dz = dz; e.ill = il;
        return e;
    endfunction

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // Issue one operation and wait (bounded) for its done pulse.
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int lat, input exp_t e);
        int n;
        q.push_back(e);
        last  = e;
        start = 1'b1; Op = op; A = a; B = b;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, " latency"}, 64'(n), 64'(lat));
    endtask

    task automatic chk_outputs_last(input string name);
        chk({name, " busy"},     64'(busy),     64'(0));
        chk({name, " done"},     64'(done),     64'(0));
        chk({name, " Result"},   64'(Result),   64'(last.res));
        chk({name, " ResultHi"}, 64'(ResultHi), 64'(last.hi));
        chk({name, " Zero"},     64'(Zero),     64'(last.z));
    endtask

    initial begin
        int n;
        // Reset state
        #12;
        chk("rst busy",     64'(busy),     64'(0));
        chk("rst done",     64'(done),     64'(0));
        chk("rst Result",   64'(Result),   64'(0));
        chk("rst ResultHi", 64'(ResultHi), 64'(0));
        chk("rst Zero",     64'(Zero),     64'(1));
        chk("rst DivZero",  64'(DivZero),  64'(0));
        chk("rst Illegal",  64'(Illegal),  64'(0));
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Back-to-back sequence: each op starts in the previous done cycle
        run_op("MULT -7*3",   3'b000, 32'hFFFFFFF9, 32'd3, 33, mk(32'hFFFFFFEB, 32'hFFFFFFFF, 0, 0));
        run_op("MULTU max^2", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, mk(32'h00000001, 32'hFFFFFFFE, 0, 0));
        run_op("DIV ovf",     3'b010, 32'h80000000, 32'hFFFFFFFF, 33, mk(32'h80000000, 32'h0, 0, 0));
        run_op("DIV -7/2",    3'b010, 32'hFFFFFFF9, 32'd2, 33, mk(32'hFFFFFFFD, 32'hFFFFFFFF, 0, 0));
        run_op("DIV 7/-2",    3'b010, 32'd7, 32'hFFFFFFFE, 33, mk(32'hFFFFFFFD, 32'd1, 0, 0));
        run_op("DIVU 7/2",    3'b011, 32'd7, 32'd2, 33, mk(32'd3, 32'd1, 0, 0));
        run_op("DIVU 100/0",  3'b011, 32'd100, 32'd0, 1, mk(32'hFFFFFFFF, 32'd100, 1, 0));
        run_op("MULTU 0*5",   3'b001, 32'd0, 32'd5, 33, mk(32'd0, 32'd0, 0, 0));
        run_op("MULT -5*-4",  3'b000, 32'hFFFFFFFB, 32'hFFFFFFFC, 33, mk(32'd20, 32'd0, 0, 0));
        run_op("DIVU big",    3'b011, 32'hFFFFFFFF, 32'h00010000, 33, mk(32'h0000FFFF, 32'h0000FFFF, 0, 0));
        run_op("ILLEGAL 110", 3'b110, 32'd9, 32'd9, 1, mk(32'd0, 32'd0, 0, 1));
        wait_cycles(3);

        // start while busy is ignored
        q.push_back(mk(32'hFFFFFFD6, 32'hFFFFFFFF, 0, 0));
        last  = mk(32'hFFFFFFD6, 32'hFFFFFFFF, 0, 0);
        start = 1'b1; Op = 3'b000; A = 32'hFFFFFFFA; B = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        wait_cycles(5); n += 5;
        chk("busy mid MULT", 64'(busy), 64'(1));
        start = 1'b1; Op = 3'b011; A = 32'd9; B = 32'd3;
        @(posedge clk); #1; n++;
        start = 1'b0;
        while (done !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("MULT -6*7 latency", 64'(n), 64'(33));
        wait_cycles(40);
        chk("no 2nd op busy", 64'(busy), 64'(0));

        // flush during DIV iterations
        start = 1'b1; Op = 3'b010; A = 32'd1000; B = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        wait_cycles(10);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk_outputs_last("flush RUN");
        wait_cycles(40);
        chk_outputs_last("after flush RUN");

        // flush together with start drops the start
        start = 1'b1; flush = 1'b1; Op = 3'b001; A = 32'd3; B = 32'd5;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        chk("flush+start busy", 64'(busy), 64'(0));
        wait_cycles(36);
        chk_outputs_last("after flush+start");

        // flush in the FIX cycle aborts the commit
        start = 1'b1; Op = 3'b001; A = 32'd3; B = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        wait_cycles(32);
        chk("in FIX busy", 64'(busy), 64'(1));
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk_outputs_last("flush FIX");
        wait_cycles(5);

        // asynchronous reset mid-RUN
        run_op("MULTU 3*5", 3'b001, 32'd3, 32'd5, 33, mk(32'd15, 32'd0, 0, 0));
        start = 1'b1; Op = 3'b000; A = 32'd11; B = 32'd13;
        @(posedge clk); #1;
        start = 1'b0;
        wait_cycles(5);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst busy",     64'(busy),     64'(0));
        chk("arst done",     64'(done),     64'(0));
        chk("arst Result",   64'(Result),   64'(0));
        chk("arst ResultHi", 64'(ResultHi), 64'(0));
        chk("arst Zero",     64'(Zero),     64'(1));
        @(negedge clk);
        reset_n = 1'b1;
        wait_cycles(40);
        chk("post arst busy", 64'(busy), 64'(0));

        chk("pending expectations", 64'(q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_muldiv_unit.md
Name: mc_muldiv_unit

Overview:
- Parametrised multi-cycle integer multiply/divide unit for the DLX pipeline EX stage. Sits beside the single-cycle ALU.
- Accepts one operation per start pulse. Iterates one bit per clock: shift-add multiply, restoring divide.
- Returns a double-width product, or quotient plus remainder, with a busy/done handshake and a pipeline flush.

Parameters:
- WIDTH, 32, operand width in bits (even, >= 4). Iteration count = WIDTH. Counter width = clog2(WIDTH)+1.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when not busy
- flush  input  1  synchronous abort from pipeline control
- Op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, others illegal
- A  input  WIDTH  multiplicand / dividend
- B  input  WIDTH  multiplier / divisor
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse; Result/ResultHi valid
- Result  output  WIDTH  product low half / quotient
- ResultHi  output  WIDTH  product high half / remainder
- Zero  output  1  Result==0 && ResultHi==0
- DivZero  output  1  last op was DIV/DIVU with B==0
- Illegal  output  1  last op used an unused Op code

Behaviour:
- Reset (async, reset_n=0): state IDLE, busy=0, done=0, Result=0, ResultHi=0, Zero=1, DivZero=0, Illegal=0, counter=0. Reset mid-operation discards all work.
- States:
  - IDLE: busy=0. On start && !flush, capture Op, sign flags and operand magnitudes; go to RUN.
  - RUN: busy=1. WIDTH iterations, one per edge. Counter counts 0..WIDTH-1.
  - FIX: busy=1. Apply signs, register outputs, assert done for that cycle, return to IDLE.
- Latency: start sampled at edge E0. Iterations occur at E1..E_WIDTH. FIX completes at E_(WIDTH+1); done is high for the cycle following it. Total latency WIDTH+1 edges.
- Back-to-back: start during the done-high cycle is accepted (state is IDLE). start while busy is ignored, with no queueing.
- Signed ops (MULT, DIV):
  - Operands are converted to magnitude at capture.
  - Product sign = sA^sB, negated over the full 2*WIDTH bits.
  - Quotient sign = sA^sB. Remainder sign = sA (truncating division).
- Unsigned ops use raw operands.
- Multiply: 2*WIDTH accumulator. Each iteration adds the multiplicand if the multiplier LSB is set, then shifts right. Result = low half, ResultHi = high half.
- Divide: restoring. Each iteration shifts {rem,quot} left, trial-subtracts the divisor, and keeps the result if non-negative, setting quot LSB.
- Overflow case: DIV with A=100..0, B=all-ones gives Result=100..0, ResultHi=0, no flag.
- Divide by zero (B==0 at capture):
  - Skip RUN and go straight to FIX.
  - Result=all-ones, ResultHi=A (raw), DivZero=1, done after E1.
- Illegal Op: skip to FIX. Result=0, ResultHi=0, Illegal=1, done after E1.
- DivZero and Illegal are cleared by the next accepted start.
- Outputs: Result, ResultHi, Zero, DivZero and Illegal change only in FIX or on reset. They hold between operations.
- Flush:
  - Synchronous, priority over everything except reset.
  - Next state is IDLE; busy=0, done=0. Outputs keep their previous values.
  - flush with start in the same cycle: start is dropped.
  - flush in the FIX cycle: FIX is aborted, so no done and no output update.

Test Plan:
- MULT A=0xFFFFFFF9 (-7), B=3 -> done exactly 33 edges after the start edge. ResultHi=0xFFFFFFFF, Result=0xFFFFFFEB, Zero=0.
- MULTU A=B=0xFFFFFFFF -> ResultHi=0xFFFFFFFE, Result=0x00000001. Then DIV A=0x80000000, B=0xFFFFFFFF started in the done cycle -> accepted; Result=0x80000000, ResultHi=0.
- DIV A=-7, B=2 -> Result=0xFFFFFFFD, ResultHi=0xFFFFFFFF. DIVU A=7, B=2 -> Result=3, ResultHi=1.
- DIVU A=100, B=0 -> done one edge after capture. DivZero=1, Result=0xFFFFFFFF, ResultHi=100. Then MULTU 0*5 -> DivZero=0, Zero=1.
- Op=3'b110 -> Illegal=1, Result=0, done after one edge. start pulsed during an active MULT busy period -> ignored; only one done.
- flush at iteration 10 of a DIV -> busy=0 next cycle, no done, outputs unchanged. reset_n low mid-RUN -> all outputs at reset values immediately.
